// File: rtl/ascon_job_sched.sv
// Round-robin job scheduler sharing one Ascon AEAD core between several requesters.
// It launches each job with its descriptors, returns completion to the owner, and aborts hung jobs with a watchdog.
module ascon_job_sched #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned DataAddrWidth = 7,
    parameter int unsigned DelayWidth    = 16,
    parameter int unsigned TimeoutWidth  = 20
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq*DataAddrWidth-1:0] req_ad_size_i,
    input  logic [NumReq*DataAddrWidth-1:0] req_pt_size_i,
    input  logic [NumReq*DelayWidth-1:0]    req_delay_i,
    output logic [NumReq-1:0]               done_valid_o,
    input  logic [NumReq-1:0]               done_ready_i,
    output logic                            done_timeout_o,
    output logic [NumReq-1:0]               grant_o,
    output logic                            busy_o,
    input  logic [TimeoutWidth-1:0]         timeout_cfg_i,
    output logic                            core_start_o,
    input  logic                            core_ready_i,
    input  logic                            core_tag_valid_i,
    output logic                            core_clear_o,
    output logic [DataAddrWidth-1:0]        core_ad_size_o,
    output logic [DataAddrWidth-1:0]        core_pt_size_o,
    output logic [DelayWidth-1:0]           core_delay_o
);

    localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [NumReq-1:0] ReqOne = NumReq'(1);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReq - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_ABORT,
        ST_RELEASE,
        ST_RESPOND
    } state_e;

    state_e                    state_q, state_d;
    logic [IdxWidth-1:0]       owner_q, owner_d;
    logic [IdxWidth-1:0]       rr_q, rr_d;
    logic [TimeoutWidth-1:0]   wd_q, wd_d;
    logic                      tmo_flag_q, tmo_flag_d;
    logic                      accept;

    logic [IdxWidth-1:0]       pick;
    logic                      pick_valid;
    int unsigned               cand;
    logic [NumReq-1:0]         pick_oh;
    logic [NumReq-1:0]         owner_oh_d;
    logic [DataAddrWidth-1:0]  ad_sel;
    logic [DataAddrWidth-1:0]  pt_sel;
    logic [DelayWidth-1:0]     delay_sel;
    logic [TimeoutWidth-1:0]   wd_inc;
    logic                      wd_expire;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!pick_valid && req_valid_i[IdxWidth'(cand)]) begin
                pick_valid = 1'b1;
                pick       = IdxWidth'(cand);
            end
        end
    end

    // Descriptor slice of the picked requester.
    always_comb begin
        ad_sel    = '0;
        pt_sel    = '0;
        delay_sel = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (pick == IdxWidth'(i)) begin
                ad_sel    = req_ad_size_i[i*DataAddrWidth +: DataAddrWidth];
                pt_sel    = req_pt_size_i[i*DataAddrWidth +: DataAddrWidth];
                delay_sel = req_delay_i[i*DelayWidth +: DelayWidth];
            end
        end
    end

    assign pick_oh    = ReqOne << pick;
    assign owner_oh_d = ReqOne << owner_d;
    assign wd_inc     = (&wd_q) ? wd_q : wd_q + 1'b1;
    assign wd_expire  = (timeout_cfg_i != '0) && (wd_q == timeout_cfg_i - 1'b1);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_q       <= '0;
            wd_q       <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            wd_q       <= wd_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    // Next-state logic; a tag seen in Run takes priority over a watchdog expiry.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        wd_d       = wd_q;
        tmo_flag_d = tmo_flag_q;
        accept     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (core_ready_i && pick_valid) begin
                    accept     = 1'b1;
                    owner_d    = pick;
                    wd_d       = '0;
                    tmo_flag_d = 1'b0;
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wd_d = wd_inc;
                if (wd_expire) begin
                    state_d = ST_ABORT;
                end else if (!core_ready_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wd_d = wd_inc;
                if (core_tag_valid_i) begin
                    state_d = ST_RELEASE;
                end else if (wd_expire) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                tmo_flag_d = 1'b1;
                state_d    = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (core_ready_i) begin
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (done_ready_i[owner_q]) begin
                    rr_d    = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            req_ready_o    <= '0;
            grant_o        <= '0;
            core_start_o   <= 1'b0;
            core_clear_o   <= 1'b0;
            done_valid_o   <= '0;
            done_timeout_o <= 1'b0;
            busy_o         <= 1'b0;
            core_ad_size_o <= '0;
            core_pt_size_o <= '0;
            core_delay_o   <= '0;
        end else begin
            req_ready_o    <= accept ? pick_oh : '0;
            grant_o        <= (state_d != ST_IDLE) ? owner_oh_d : '0;
            core_start_o   <= (state_d == ST_LAUNCH) || (state_d == ST_RUN);
            core_clear_o   <= (state_d == ST_ABORT);
            done_valid_o   <= (state_d == ST_RESPOND) ? owner_oh_d : '0;
            done_timeout_o <= (state_d == ST_RESPOND) && tmo_flag_d;
            busy_o         <= (state_d != ST_IDLE);
            if (accept) begin
                core_ad_size_o <= ad_sel;
                core_pt_size_o <= pt_sel;
                core_delay_o   <= delay_sel;
            end
        end
    end

endmodule

// File: tb/tb_ascon_job_sched.sv
// Scoreboard bench for ascon_job_sched: a small core model, requesters that hold valid until accepted,
// and queues of expected accepts/completions checked as the scheduler produces them.
module tb_ascon_job_sched;

    localparam int unsigned NumReq = 2;
    localparam int unsigned DAW    = 7;
    localparam int unsigned DW     = 16;
    localparam int unsigned TW     = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2*DAW-1:0]  req_ad_size;
    logic [2*DAW-1:0]  req_pt_size;
    logic [2*DW-1:0]   req_delay;
    logic [1:0]        done_valid;
    logic [1:0]        done_ready;
    logic              done_timeout;
    logic [1:0]        grant;
    logic              busy;
    logic [TW-1:0]     timeout_cfg;
    logic              core_start;
    logic              core_ready;
    logic              core_tag_valid;
    logic              core_clear;
    logic [DAW-1:0]    core_ad_size;
    logic [DAW-1:0]    core_pt_size;
    logic [DW-1:0]     core_delay;

    always #5 clk = ~clk;

    ascon_job_sched #(
        .NumReq(NumReq), .DataAddrWidth(DAW), .DelayWidth(DW), .TimeoutWidth(TW)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_ad_size_i(req_ad_size), .req_pt_size_i(req_pt_size), .req_delay_i(req_delay),
        .done_valid_o(done_valid), .done_ready_i(done_ready), .done_timeout_o(done_timeout),
        .grant_o(grant), .busy_o(busy), .timeout_cfg_i(timeout_cfg),
        .core_start_o(core_start), .core_ready_i(core_ready), .core_tag_valid_i(core_tag_valid),
        .core_clear_o(core_clear),
        .core_ad_size_o(core_ad_size), .core_pt_size_o(core_pt_size), .core_delay_o(core_delay)
    );

    // Core model: idle -> busy for job_len cycles -> done (tag) until start drops; clear aborts.
    typedef enum logic [1:0] {C_IDLE, C_BUSY, C_DONE} cst_e;
    cst_e cst = C_IDLE;
    int   ccnt = 0;
    int   job_len = 5;
    bit   hang = 1'b0;

    always @(posedge clk) begin
        if (!rst_n || core_clear) begin
            cst  <= C_IDLE;
            ccnt <= 0;
        end else begin
            case (cst)
                C_IDLE: if (core_start) begin cst <= C_BUSY; ccnt <= 0; end
                C_BUSY: if (!hang && ccnt == job_len - 1) cst <= C_DONE; else ccnt <= ccnt + 1;
                C_DONE: if (!core_start) cst <= C_IDLE;
                default: cst <= C_IDLE;
            endcase
        end
    end
    assign core_ready     = (cst == C_IDLE);
    assign core_tag_valid = (cst == C_DONE);

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int clear_count = 0;
    int remaining[NumReq];
    int ad_tab[NumReq];
    int pt_tab[NumReq];
    int dl_tab[NumReq];
    bit accept_en = 1'b1;
    int exp_acc[$];
    int exp_done[$];

    task automatic update_valid();
        for (int i = 0; i < NumReq; i++) req_valid[i] = (remaining[i] > 0);
    endtask

    task automatic set_desc(input int i, input int ad, input int pt, input int dl);
        ad_tab[i] = ad; pt_tab[i] = pt; dl_tab[i] = dl;
        req_ad_size[i*DAW +: DAW] = DAW'(ad);
        req_pt_size[i*DAW +: DAW] = DAW'(pt);
        req_delay[i*DW +: DW]     = DW'(dl);
    endtask

    // One cycle: sample at negedge, score accepts/completions, then drive requester inputs.
    task automatic tick();
        logic [1:0] oh;
        int o;
        int e;
        @(negedge clk);
        cycle++;
        done_ready = accept_en ? done_valid : 2'b00;
        if (core_clear) clear_count++;
        if (req_ready != 2'b00) begin
            checks++;
            if (exp_acc.size() == 0) begin
                errors++;
                $display("FAIL accept_unexpected: got req_ready=%b, expected none", req_ready);
            end else begin
                o  = exp_acc.pop_front();
                oh = 2'b01 << o;
                if (req_ready !== oh) begin
                    errors++;
                    $display("FAIL accept_owner: got req_ready=%b, expected %b", req_ready, oh);
                end
                checks++;
                if ({core_ad_size, core_pt_size, core_delay} !== {DAW'(ad_tab[o]), DAW'(pt_tab[o]), DW'(dl_tab[o])}) begin
                    errors++;
                    $display("FAIL descriptor: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                             core_ad_size, core_pt_size, core_delay, ad_tab[o], pt_tab[o], dl_tab[o]);
                end
            end
            for (int i = 0; i < NumReq; i++) if (req_ready[i] && remaining[i] > 0) remaining[i]--;
        end
        if ((done_valid & done_ready) != 2'b00) begin
            checks++;
            if (exp_done.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got done_valid=%b, expected none", done_valid);
            end else begin
                e  = exp_done.pop_front();
                oh = 2'b01 << (e / 2);
                if (done_valid !== oh || done_timeout !== 1'(e % 2)) begin
                    errors++;
                    $display("FAIL done_owner: got done_valid=%b timeout=%b, expected %b timeout=%0d",
                             done_valid, done_timeout, oh, e % 2);
                end
            end
        end
        if (done_valid != 2'b00) begin
            checks++;
            if ($countones(done_valid) > 1) begin
                errors++;
                $display("FAIL done_onehot: got done_valid=%b, expected at most one bit", done_valid);
            end
        end
        update_valid();
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n = 0;
        while (!(remaining[0] == 0 && remaining[1] == 0 && !busy && exp_acc.size() == 0 &&
                 exp_done.size() == 0) && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("FAIL %s_idle: got busy=%b acc_left=%0d done_left=%0d after %0d cycles, expected drained",
                     name, busy, exp_acc.size(), exp_done.size(), n);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({req_ready, done_valid, done_timeout, grant, busy, core_start, core_clear} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b dv=%b to=%b gnt=%b busy=%b start=%b clr=%b, expected all 0",
                     req_ready, done_valid, done_timeout, grant, busy, core_start, core_clear);
        end
        checks++;
        if ({core_ad_size, core_pt_size, core_delay} !== 30'd0) begin
            errors++;
            $display("FAIL reset_desc: got %0d/%0d/%0d, expected 0/0/0", core_ad_size, core_pt_size, core_delay);
        end
    endtask

    task automatic test_single_job();
        int n = 0;
        set_desc(0, 2, 3, 4);
        set_desc(1, 9, 8, 7);
        job_len = 6;
        exp_acc.push_back(0);
        exp_done.push_back(0);
        remaining[0] = 1;
        update_valid();
        while (req_ready == 2'b00 && n < 50) begin tick(); n++; end
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_accept: got req_ready=%b, expected 01", req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 2'b00 || core_start !== 1'b1 || grant !== 2'b01) begin
            errors++;
            $display("FAIL single_launch: got rdy=%b start=%b gnt=%b, expected 00/1/01", req_ready, core_start, grant);
        end
        n = 0;
        while (!core_tag_valid && n < 50) begin tick(); n++; end
        checks++;
        if (core_tag_valid !== 1'b1 || core_start !== 1'b1) begin
            errors++;
            $display("FAIL single_run: got tag=%b start=%b, expected start held until tag", core_tag_valid, core_start);
        end
        tick();
        checks++;
        if (core_start !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got start=%b, expected 0", core_start);
        end
        n = 0;
        while (done_valid == 2'b00 && n < 50) begin tick(); n++; end
        checks++;
        if (done_valid !== 2'b01 || done_timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got dv=%b to=%b, expected 01/0", done_valid, done_timeout);
        end
        wait_idle("single", 50);
        checks++;
        if ({core_ad_size, core_pt_size, core_delay} !== {7'd2, 7'd3, 16'd4}) begin
            errors++;
            $display("FAIL desc_hold: got %0d/%0d/%0d, expected 2/3/4", core_ad_size, core_pt_size, core_delay);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        job_len = 4;
        exp_acc.push_back(0); exp_acc.push_back(1); exp_acc.push_back(0); exp_acc.push_back(1);
        exp_done.push_back(0); exp_done.push_back(2); exp_done.push_back(0); exp_done.push_back(2);
        remaining[0] = 2;
        remaining[1] = 2;
        update_valid();
        wait_idle("round_robin", 400);
    endtask

    task automatic test_backpressure();
        int n = 0;
        accept_en = 1'b0;
        exp_acc.push_back(0);
        exp_acc.push_back(1);
        exp_done.push_back(0);
        exp_done.push_back(2);
        remaining[0] = 1;
        remaining[1] = 1;
        update_valid();
        while (done_valid == 2'b00 && n < 100) begin tick(); n++; end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (done_valid !== 2'b01 || busy !== 1'b1 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL backpressure_hold: cycle %0d got dv=%b busy=%b rdy=%b, expected 01/1/00",
                         i, done_valid, busy, req_ready);
            end
        end
        accept_en = 1'b1;
        wait_idle("backpressure", 200);
    endtask

    task automatic test_watchdog_abort();
        int n = 0;
        int clr0;
        timeout_cfg = TW'(100);
        hang = 1'b1;
        clr0 = clear_count;
        exp_acc.push_back(0);
        exp_done.push_back(1);
        remaining[0] = 1;
        update_valid();
        while (!core_start && n < 50) begin tick(); n++; end
        n = 0;
        while (!core_clear && n < 200) begin tick(); n++; end
        checks++;
        if (n !== 100) begin
            errors++;
            $display("FAIL abort_latency: got clear %0d cycles after launch, expected 100", n);
        end
        tick();
        checks++;
        if (core_clear !== 1'b0 || clear_count !== clr0 + 1) begin
            errors++;
            $display("FAIL abort_pulse: got clear=%b pulses=%0d, expected 0 and 1", core_clear, clear_count - clr0);
        end
        wait_idle("abort", 100);
        hang = 1'b0;
        job_len = 10;
        exp_acc.push_back(1);
        exp_done.push_back(2);
        remaining[1] = 1;
        update_valid();
        wait_idle("after_abort", 100);
    endtask

    task automatic test_tag_wins();
        int clr0;
        timeout_cfg = TW'(20);
        clr0 = clear_count;
        job_len = 18;
        exp_acc.push_back(0);
        exp_done.push_back(0);
        remaining[0] = 1;
        update_valid();
        wait_idle("tag_wins", 100);
        checks++;
        if (clear_count !== clr0) begin
            errors++;
            $display("FAIL tag_wins_clear: got %0d clear pulses, expected 0", clear_count - clr0);
        end
        job_len = 19;
        exp_acc.push_back(1);
        exp_done.push_back(3);
        remaining[1] = 1;
        update_valid();
        wait_idle("tag_late", 100);
        checks++;
        if (clear_count !== clr0 + 1) begin
            errors++;
            $display("FAIL tag_late_clear: got %0d clear pulses, expected 1", clear_count - clr0);
        end
    endtask

    task automatic test_no_timeout();
        int clr0;
        timeout_cfg = '0;
        clr0 = clear_count;
        job_len = 5000;
        exp_acc.push_back(0);
        exp_done.push_back(0);
        remaining[0] = 1;
        update_valid();
        wait_idle("no_timeout", 6000);
        checks++;
        if (clear_count !== clr0) begin
            errors++;
            $display("FAIL no_timeout_clear: got %0d clear pulses, expected 0", clear_count - clr0);
        end
    endtask

    task automatic test_reset_in_run();
        int n = 0;
        job_len = 50;
        exp_acc.push_back(1);
        remaining[1] = 1;
        update_valid();
        while (core_ready && n < 50) begin tick(); n++; end
        tick();
        tick();
        checks++;
        if (core_start !== 1'b1 || grant !== 2'b10) begin
            errors++;
            $display("FAIL pre_reset_run: got start=%b gnt=%b, expected 1/10", core_start, grant);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({req_ready, done_valid, done_timeout, grant, busy, core_start, core_clear} !== 10'd0 ||
            {core_ad_size, core_pt_size, core_delay} !== 30'd0) begin
            errors++;
            $display("FAIL run_reset: got gnt=%b start=%b busy=%b dv=%b desc=%0d/%0d/%0d, expected all 0",
                     grant, core_start, busy, done_valid, core_ad_size, core_pt_size, core_delay);
        end
        rst_n = 1'b1;
        job_len = 5;
        exp_acc.push_back(0);
        exp_acc.push_back(1);
        exp_done.push_back(0);
        exp_done.push_back(2);
        remaining[0] = 1;
        remaining[1] = 1;
        update_valid();
        wait_idle("after_reset", 200);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = '0;
        req_ad_size = '0;
        req_pt_size = '0;
        req_delay   = '0;
        done_ready  = '0;
        timeout_cfg = '0;
        for (int i = 0; i < NumReq; i++) begin
            remaining[i] = 0;
            ad_tab[i] = 0; pt_tab[i] = 0; dl_tab[i] = 0;
        end
        test_reset();
        test_single_job();
        test_round_robin();
        test_backpressure();
        test_watchdog_abort();
        test_tag_wins();
        test_no_timeout();
        test_reset_in_run();
        checks++;
        if (exp_acc.size() != 0 || exp_done.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d accepts and %0d completions left, expected 0",
                     exp_acc.size(), exp_done.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
